flash_playback_sequencer: RTL
=============================

FLASH_PLAYBACK_SEQUENCER -- requirements
Module: flash_playback_sequencer

Interface
REQ-001 Parameter ADDR_W, default 23: flash word-address width.
REQ-002 Parameter START_ADDR, default 0: first word address of the playback region.
REQ-003 Parameter END_ADDR, default 23'h7FFFF: last word address of the region, inclusive; START_ADDR < END_ADDR.
REQ-004 address_clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 play  in  1  level; 1 = run, 0 = pause.
REQ-007 dir  in  1  0 = forward, 1 = reverse.
REQ-008 restart  in  1  one-cycle pulse; jump to the region start (forward) or region end (reverse).
REQ-009 sample_tick  in  1  one-cycle pulse; consumer requests the next 16-bit sample.
REQ-010 flash_mem_waitrequest  in  1  Avalon-MM slave stall.
REQ-011 flash_mem_readdatavalid  in  1  Avalon-MM read data strobe.
REQ-012 flash_mem_readdata  in  32  Avalon-MM read data.
REQ-013 flash_mem_read  out  1  Avalon-MM read request.
REQ-014 flash_mem_address  out  ADDR_W  word address of the current read.
REQ-015 flash_mem_byteenable  out  4  constant 4'hF.
REQ-016 sample_out  out  16  registered audio sample.
REQ-017 sample_valid  out  1  one-cycle pulse; sample_out is updated in the same cycle.
REQ-018 underrun  out  1  one-cycle pulse; a sample_tick arrived with no word available.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, REQ, WAIT_DATA, FIRST and SECOND.
REQ-020 IDLE: flash_mem_read=0; if play=1, go to REQ on the next cycle.
REQ-021 REQ: flash_mem_read=1 and address=addr, both held while waitrequest=1; on the cycle waitrequest=0, go to WAIT_DATA and deassert read on the next cycle.
REQ-022 WAIT_DATA: on readdatavalid=1, latch readdata into the word register, latch dir into half_dir, and go to FIRST.
REQ-023 FIRST, on sample_tick with play=1: sample_out = word[15:0] if half_dir=0, else word[31:16]; go to SECOND.
REQ-024 SECOND, on sample_tick with play=1: output the other half; advance addr; go to REQ if play=1, else IDLE.
REQ-025 sample_valid SHALL pulse exactly one cycle after the accepted sample_tick.
REQ-026 Forward advance: addr==END_ADDR -> START_ADDR, else addr+1.
REQ-027 Reverse advance: addr==START_ADDR -> END_ADDR, else addr-1.
REQ-028 A dir change SHALL affect only the next address advance and the next word latch, never the half currently being served.
REQ-029 sample_tick in REQ or WAIT_DATA with play=1: underrun pulses, sample_valid stays 0, sample_out holds its value.
REQ-030 play=0 in FIRST or SECOND: sample_tick is ignored (no underrun), state and word are held.
REQ-031 play=0 in REQ or WAIT_DATA: the issued read SHALL complete; no abort while waitrequest=1.
REQ-032 restart in IDLE, FIRST or SECOND:
  - load addr with START_ADDR if dir=0, else END_ADDR;
  - discard the word;
  - go to IDLE.
REQ-033 restart in REQ or WAIT_DATA:
  - set a pending flag;
  - complete the read and discard its data;
  - then load addr as in REQ-032 and go to IDLE.
REQ-034 restart and sample_tick in the same cycle: restart wins; no sample_valid, no underrun.
REQ-035 readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-036 At most one read SHALL be outstanding at any time.

Reset
REQ-037 On reset the block SHALL apply:
  - state=IDLE, addr=START_ADDR, word=0, pending restart flag cleared;
  - flash_mem_read=0, sample_out=0, sample_valid=0, underrun=0;
  - flash_mem_address=START_ADDR.
REQ-038 reset SHALL override every other input, including mid-read; flash_mem_read drops on the next edge.

Verification
REQ-039 Forward wrap: START_ADDR=0, END_ADDR=3, dir=0, play=1, zero-wait flash, two ticks per word -> addresses 0,1,2,3,0; per word, sample_out = low half then high half.
REQ-040 Reverse wrap: same setup with dir=1 -> addresses 0,3,2,1,0; per word, sample_out = high half then low half.
REQ-041 waitrequest held 5 cycles in REQ -> flash_mem_read and flash_mem_address stable for all 6 cycles; exactly one read accepted.
REQ-042 sample_tick while in WAIT_DATA -> underrun=1 for 1 cycle, sample_valid=0, sample_out unchanged.
REQ-043 restart during WAIT_DATA at addr=2, dir=0 -> data at addr 2 never appears on sample_out; next read is addr 0.
REQ-044 reset asserted while REQ is stalled -> read=0 on the next edge; all outputs at their reset values; a later stray readdatavalid is ignored.

Source files
------------

// File: rtl/flash_playback_sequencer.sv
// ---------------------------------------------------------------------------
// flash_playback_sequencer
//
// Streams 16-bit audio samples out of a region of 32-bit flash words. Each
// flash word holds two samples. The sequencer reads one word at a time over
// an Avalon-MM master port. It then hands out the two halves on consecutive
// sample_tick requests. After that it advances the word address, forwards or
// in reverse, and wraps around at the region boundaries.
//
// Ports
//   address_clk              : clock, all logic on the rising edge
//   reset                    : synchronous, active-high reset
//   play                     : 1 = run, 0 = pause
//   dir                      : 0 = forward, 1 = reverse
//   restart                  : pulse, jump to the region start (fwd) or end (rev)
//   sample_tick              : pulse, consumer asks for the next sample
//   flash_mem_waitrequest    : Avalon-MM slave stall
//   flash_mem_readdatavalid  : Avalon-MM read data strobe
//   flash_mem_readdata       : Avalon-MM read data (one 32-bit word)
//   flash_mem_read           : Avalon-MM read request
//   flash_mem_address        : word address of the current read
//   flash_mem_byteenable     : always 4'hF (whole words only)
//   sample_out               : registered audio sample
//   sample_valid             : one-cycle pulse, sample_out updated this cycle
//   underrun                 : one-cycle pulse, tick arrived with no word ready
// ---------------------------------------------------------------------------
module flash_playback_sequencer #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
    input  logic              address_clk,
    input  logic              reset,
    input  logic              play,
    input  logic              dir,
    input  logic              restart,
    input  logic              sample_tick,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [31:0]       flash_mem_readdata,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              underrun
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        FIRST,
        SECOND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       word;
    logic [31:0]       word_next;
    logic              half_dir;
    logic              half_dir_next;
    logic              restart_pending;
    logic              restart_pending_next;
    logic [15:0]       sample_next;
    logic              sample_valid_next;
    logic              underrun_next;

    // Next word address inside the circular region.
    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a,
                                                  input logic             d);
        logic [ADDR_W-1:0] r;
        if (!d) begin
            r = (a == END_ADDR) ? START_ADDR : a + 1'b1;
        end else begin
            r = (a == START_ADDR) ? END_ADDR : a - 1'b1;
        end
        return r;
    endfunction

    // A restart begins at whichever end of the region playback moves away from.
    function automatic logic [ADDR_W-1:0] restart_target(input logic d);
        return d ? END_ADDR : START_ADDR;
    endfunction

    // The read request is a plain decode of the state register. Reset forces
    // IDLE, so the request drops on the edge that samples reset.
    assign flash_mem_read       = (state == REQ);
    assign flash_mem_address    = addr;
    assign flash_mem_byteenable = 4'hF;

    // State and datapath registers. All next values come from the
    // combinational process below.
    always_ff @(posedge address_clk) begin
        if (reset) begin
            state           <= IDLE;
            addr            <= START_ADDR;
            word            <= '0;
            half_dir        <= 1'b0;
            restart_pending <= 1'b0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            state           <= state_next;
            addr            <= addr_next;
            word            <= word_next;
            half_dir        <= half_dir_next;
            restart_pending <= restart_pending_next;
            sample_out      <= sample_next;
            sample_valid    <= sample_valid_next;
            underrun        <= underrun_next;
        end
    end

    // Next-state and datapath decisions. A read is never abandoned once
    // issued. A restart seen while a read is in flight is remembered. The
    // returning data is then thrown away before jumping.
    always_comb begin
        state_next           = state;
        addr_next            = addr;
        word_next            = word;
        half_dir_next        = half_dir;
        restart_pending_next = restart_pending;
        sample_next          = sample_out;
        sample_valid_next    = 1'b0;
        underrun_next        = 1'b0;

        case (state)
            IDLE: begin
                if (restart) begin
                    addr_next = restart_target(dir);
                    word_next = '0;
                end else if (play) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                if (restart) begin
                    restart_pending_next = 1'b1;
                end else if (sample_tick && play) begin
                    underrun_next = 1'b1;
                end
                if (!flash_mem_waitrequest) begin
                    state_next = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    if (restart_pending || restart) begin
                        addr_next            = restart_target(dir);
                        word_next            = '0;
                        restart_pending_next = 1'b0;
                        state_next           = IDLE;
                    end else begin
                        word_next     = flash_mem_readdata;
                        half_dir_next = dir;
                        state_next    = FIRST;
                    end
                end else if (restart) begin
                    restart_pending_next = 1'b1;
                end
                if (!restart && sample_tick && play) begin
                    underrun_next = 1'b1;
                end
            end

            // half_dir was captured when the word arrived. A later dir change
            // therefore cannot reorder the halves of the word being served.
            FIRST: begin
                if (restart) begin
                    addr_next  = restart_target(dir);
                    word_next  = '0;
                    state_next = IDLE;
                end else if (sample_tick && play) begin
                    sample_next       = half_dir ? word[31:16] : word[15:0];
                    sample_valid_next = 1'b1;
                    state_next        = SECOND;
                end
            end

            SECOND: begin
                if (restart) begin
                    addr_next  = restart_target(dir);
                    word_next  = '0;
                    state_next = IDLE;
                end else if (sample_tick && play) begin
                    sample_next       = half_dir ? word[15:0] : word[31:16];
                    sample_valid_next = 1'b1;
                    addr_next         = advance(addr, dir);
                    state_next        = play ? REQ : IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
